bg_affine_multi_engine: RTL and testbench
=========================================

Name: bg_affine_multi_engine

Overview:
- Parametrised N-channel affine (rotation/scale) coordinate generator for the background processing circuit.
- Each channel holds its own reference-point accumulators, steps per pixel (PA/PC) and per row (PB/PD), and produces a registered texture coordinate one cycle after each pixel step.
- New relative to the current per-BG unit:
  - channel count and fixed-point widths are parameters;
  - per-channel wraparound/transparent overflow mode with selectable map size;
  - mid-frame reference writes are latched and applied at the next row.

Parameters:
- NUM_CH, 2, number of affine backgrounds.
- REF_W, 28, reference/accumulator width, signed two's complement.
- FRAC_W, 8, fractional bits in reference and PA..PD.
- COORD_W, 10, output integer coordinate width; must be >= 10.
- CH_W, $clog2(NUM_CH) (min 1), channel index width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pa, pb, pc, pd  in  16*NUM_CH  signed per-channel dx, dmx, dy, dmy; channel i at [16i+15:16i]
- refx, refy  in  REF_W*NUM_CH  MMIO reference point per channel
- ref_wr  in  NUM_CH  one-cycle strobe: channel's refx/refy register was written
- wrap_en  in  NUM_CH  1 = wrap out-of-range coordinates, 0 = flag transparent
- map_size  in  2*NUM_CH  map edge = 128 << map_size pixels
- newframe  in  1  first cycle of frame
- steprow  in  1  last cycle of a row
- step  in  1  sample and advance the channel selected by ch
- ch  in  CH_W  channel for step
- out_valid  out  1  output coordinate valid
- out_ch  out  CH_W  channel of output
- out_x, out_y  out  COORD_W  integer texture coordinate
- out_transparent  out  1  coordinate outside map with wrap_en = 0

Behaviour:
- Per-channel state:
  - line_x, line_y: row-start accumulators, REF_W.
  - cur_x, cur_y: current-pixel accumulators, REF_W.
  - pend: pending reference reload flag.
- Reset: all accumulators 0, pend 0, out_valid 0, out_ch 0, out_x 0, out_y 0, out_transparent 0.
- Sign extension: each 16-bit param is extended to REF_W by replicating bit 15. No saturation; all sums wrap modulo 2^REF_W.
- Update priority per channel, highest first: newframe > steprow > step.
- newframe:
  - line <= ref, cur <= ref for every channel.
  - pend <= 0.
  - step in the same cycle is ignored; out_valid <= 0.
- steprow, per channel:
  - if pend or ref_wr[i] this cycle: line <= ref, cur <= ref, pend <= 0.
  - else: line <= line + dmx/dmy, cur <= line + dmx/dmy.
  - step in the same cycle is ignored; out_valid <= 0.
- ref_wr[i] with neither newframe nor steprow: pend[i] <= 1. Accumulators are unchanged, so a mid-row write never disturbs the current row.
- step, when neither newframe nor steprow:
  - cur_x[ch] += dx, cur_y[ch] += dy.
  - Output register captures the pre-increment cur of ch, so latency is 1 cycle.
  - out_valid <= 1, out_ch <= ch.
- No step in a cycle: out_valid <= 0. Other out_* fields hold their last values.
- ch >= NUM_CH with step: no state change; out_valid <= 1 with out_transparent = 1, out_x = out_y = 0.
- Coordinate mapping, for sampled value v:
  - ix = v >> FRAC_W (arithmetic shift); M = 128 << map_size[ch].
  - In range (0 <= ix < M): output = ix[COORD_W-1:0], transparent 0.
  - Out of range and wrap_en = 1: output = ix & (M-1), transparent 0. Negative ix wraps correctly because M is a power of two.
  - Out of range and wrap_en = 0: transparent 1, output = ix & (M-1).
  - out_transparent is the OR of the x and y conditions.
- Reset asserted mid-row: state clears immediately (async). The first frame requires newframe before valid output.

Test Plan:
- Identity, ch0: pa=0x0100, pd=0x0100, pb=pc=0, ref=(0,0), newframe, then 4 steps -> out_x 0,1,2,3 with out_y 0, one cycle after each step; steprow then step -> (0,1).
- Scale 0.5, ch1: pa=0x0080, refx=0x000A00 -> out_x 10,10,11,11.
- Negative wrap: wrap_en=1, map_size=0, refx=-0x200 (-2.0), pa=0x0100 -> out_x 126,127,0, transparent 0. Same with wrap_en=0 -> transparent 1,1,0.
- Mid-row write: ref_wr[0] with new refy=0x3200 mid-row -> remaining row unchanged; after steprow, first step gives out_y 50, not old line + pd.
- Priority: newframe together with step and steprow -> all channels reload ref, out_valid 0 next cycle. Interleaved ch0/ch1 steps advance only their own accumulators.
- Reset pulse mid-row -> outputs 0 and out_valid 0 asynchronously; no valid output until steps after newframe.

Source files
------------

// File: rtl/bg_affine_multi_engine.sv
// N-channel affine background coordinate generator: per-channel row/pixel
// accumulators stepped by PA..PD, with a one-cycle registered texture coordinate.
module bg_affine_multi_engine #(
    parameter int NUM_CH  = 2,
    parameter int REF_W   = 28,
    parameter int FRAC_W  = 8,
    parameter int COORD_W = 10,
    parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [16*NUM_CH-1:0]    pa,
    input  logic [16*NUM_CH-1:0]    pb,
    input  logic [16*NUM_CH-1:0]    pc,
    input  logic [16*NUM_CH-1:0]    pd,
    input  logic [REF_W*NUM_CH-1:0] refx,
    input  logic [REF_W*NUM_CH-1:0] refy,
    input  logic [NUM_CH-1:0]       ref_wr,
    input  logic [NUM_CH-1:0]       wrap_en,
    input  logic [2*NUM_CH-1:0]     map_size,
    input  logic                    newframe,
    input  logic                    steprow,
    input  logic                    step,
    input  logic [CH_W-1:0]         ch,
    output logic                    out_valid,
    output logic [CH_W-1:0]         out_ch,
    output logic [COORD_W-1:0]      out_x,
    output logic [COORD_W-1:0]      out_y,
    output logic                    out_transparent
);

    logic [NUM_CH-1:0][REF_W-1:0] line_x, line_y, cur_x, cur_y;
    logic [NUM_CH-1:0]            pend;

    logic                         ch_ok;
    logic [REF_W-1:0]             samp_x, samp_y;
    logic [1:0]                   samp_ms;
    logic                         samp_wrap;
    logic [COORD_W:0]             map_x, map_y;

    function automatic logic [REF_W-1:0] sext16(input logic [15:0] p);
        return {{(REF_W-16){p[15]}}, p};
    endfunction

    // Returns {transparent, coordinate}; masking with M-1 also wraps negatives.
    function automatic logic [COORD_W:0] map_coord(input logic [REF_W-1:0] v,
                                                   input logic [1:0] ms,
                                                   input logic wrap);
        logic [REF_W-1:0]   ix;
        logic [10:0]        m;
        logic               in_range;
        logic [COORD_W-1:0] mask;
        ix       = REF_W'($signed(v) >>> FRAC_W);
        m        = 11'd128 << ms;
        in_range = !ix[REF_W-1] && (ix < REF_W'(m));
        mask     = COORD_W'(m - 11'd1);
        return {!in_range && !wrap, ix[COORD_W-1:0] & mask};
    endfunction

    always_comb begin
        ch_ok     = 1'b0;
        samp_x    = '0;
        samp_y    = '0;
        samp_ms   = 2'd0;
        samp_wrap = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(ch) == i) begin
                ch_ok     = 1'b1;
                samp_x    = cur_x[i];
                samp_y    = cur_y[i];
                samp_ms   = map_size[2*i +: 2];
                samp_wrap = wrap_en[i];
            end
        end
        map_x = map_coord(samp_x, samp_ms, samp_wrap);
        map_y = map_coord(samp_y, samp_ms, samp_wrap);
    end

    // Reference writes outside a row boundary only arm pend, so the current row is never disturbed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            line_x <= '0;
            line_y <= '0;
            cur_x  <= '0;
            cur_y  <= '0;
            pend   <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (newframe || (steprow && (pend[i] || ref_wr[i]))) begin
                    line_x[i] <= refx[REF_W*i +: REF_W];
                    line_y[i] <= refy[REF_W*i +: REF_W];
                    cur_x[i]  <= refx[REF_W*i +: REF_W];
                    cur_y[i]  <= refy[REF_W*i +: REF_W];
                    pend[i]   <= 1'b0;
                end else if (steprow) begin
                    line_x[i] <= line_x[i] + sext16(pb[16*i +: 16]);
                    line_y[i] <= line_y[i] + sext16(pd[16*i +: 16]);
                    cur_x[i]  <= line_x[i] + sext16(pb[16*i +: 16]);
                    cur_y[i]  <= line_y[i] + sext16(pd[16*i +: 16]);
                end else begin
                    if (ref_wr[i]) begin
                        pend[i] <= 1'b1;
                    end
                    if (step && int'(ch) == i) begin
                        cur_x[i] <= cur_x[i] + sext16(pa[16*i +: 16]);
                        cur_y[i] <= cur_y[i] + sext16(pc[16*i +: 16]);
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid       <= 1'b0;
            out_ch          <= '0;
            out_x           <= '0;
            out_y           <= '0;
            out_transparent <= 1'b0;
        end else if (newframe || steprow || !step) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b1;
            out_ch    <= ch;
            if (ch_ok) begin
                out_x           <= map_x[COORD_W-1:0];
                out_y           <= map_y[COORD_W-1:0];
                out_transparent <= map_x[COORD_W] | map_y[COORD_W];
            end else begin
                out_x           <= '0;
                out_y           <= '0;
                out_transparent <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bg_affine_multi_engine.sv
// Bench for bg_affine_multi_engine: directed table, hand sequences for
// multi-cycle corners, and random traffic checked against a reference model.
module tb_bg_affine_multi_engine;

    localparam int NUM_CH  = 2;
    localparam int REF_W   = 28;
    localparam int COORD_W = 10;

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic [16*NUM_CH-1:0]    pa = '0, pb = '0, pc = '0, pd = '0;
    logic [REF_W*NUM_CH-1:0] refx = '0, refy = '0;
    logic [NUM_CH-1:0]       ref_wr = '0, wrap_en = '0;
    logic [2*NUM_CH-1:0]     map_size = '0;
    logic                    newframe = 1'b0, steprow = 1'b0, step = 1'b0;
    logic [0:0]              ch = '0;
    logic                    out_valid;
    logic [0:0]              out_ch;
    logic [COORD_W-1:0]      out_x, out_y;
    logic                    out_transparent;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state: plain signed integers kept modulo 2^28.
    longint m_lx[NUM_CH], m_ly[NUM_CH], m_cx[NUM_CH], m_cy[NUM_CH];
    bit     m_pend[NUM_CH];
    bit     m_v, m_t;
    int     m_ch;
    longint m_x, m_y;

    typedef struct {
        logic nf, sr, st;
        logic [0:0] c;
        logic [1:0] rw;
        logic ev;
        int ech, ex, ey;
        logic et;
    } vec_t;

    vec_t tbl[12];

    bg_affine_multi_engine dut (
        .clock(clock), .reset(reset),
        .pa(pa), .pb(pb), .pc(pc), .pd(pd),
        .refx(refx), .refy(refy), .ref_wr(ref_wr),
        .wrap_en(wrap_en), .map_size(map_size),
        .newframe(newframe), .steprow(steprow), .step(step), .ch(ch),
        .out_valid(out_valid), .out_ch(out_ch), .out_x(out_x), .out_y(out_y),
        .out_transparent(out_transparent)
    );

    always #5 clock = ~clock;

    function automatic longint wrap28(input longint v);
        longint r;
        r = v & ((longint'(1) << 28) - 1);
        if (r >= (longint'(1) << 27)) r = r - (longint'(1) << 28);
        return r;
    endfunction

    function automatic longint pget(input logic [16*NUM_CH-1:0] bus, input int i);
        logic [15:0] p;
        p = bus[16*i +: 16];
        return longint'($signed(p));
    endfunction

    function automatic longint rget(input logic [REF_W*NUM_CH-1:0] bus, input int i);
        logic [REF_W-1:0] r;
        r = bus[REF_W*i +: REF_W];
        return wrap28(longint'(r));
    endfunction

    function automatic void map_model(input longint v, input int ms, input bit we,
                                      output longint c, output bit t);
        longint ix, m;
        m = 128 * (longint'(1) << ms);
        if (v >= 0) ix = v / 256;
        else        ix = -((-v + 255) / 256);
        c = ((ix % m) + m) % m;
        t = !we && (ix < 0 || ix >= m);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_lx[i] = 0; m_ly[i] = 0; m_cx[i] = 0; m_cy[i] = 0; m_pend[i] = 0;
        end
        m_v = 0; m_t = 0; m_ch = 0; m_x = 0; m_y = 0;
    endtask

    task automatic model_update();
        longint cx, cy;
        bit tx, ty;
        int c;
        if (newframe) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_lx[i] = rget(refx, i); m_ly[i] = rget(refy, i);
                m_cx[i] = m_lx[i];       m_cy[i] = m_ly[i];
                m_pend[i] = 0;
            end
            m_v = 0;
        end else if (steprow) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (m_pend[i] || ref_wr[i]) begin
                    m_lx[i] = rget(refx, i); m_ly[i] = rget(refy, i);
                end else begin
                    m_lx[i] = wrap28(m_lx[i] + pget(pb, i));
                    m_ly[i] = wrap28(m_ly[i] + pget(pd, i));
                end
                m_cx[i] = m_lx[i]; m_cy[i] = m_ly[i];
                m_pend[i] = 0;
            end
            m_v = 0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) if (ref_wr[i]) m_pend[i] = 1;
            if (step) begin
                c = int'(ch);
                m_v = 1;
                m_ch = c;
                map_model(m_cx[c], int'(map_size[2*c +: 2]), wrap_en[c], cx, tx);
                map_model(m_cy[c], int'(map_size[2*c +: 2]), wrap_en[c], cy, ty);
                m_x = cx; m_y = cy; m_t = tx | ty;
                m_cx[c] = wrap28(m_cx[c] + pget(pa, c));
                m_cy[c] = wrap28(m_cy[c] + pget(pc, c));
            end else begin
                m_v = 0;
            end
        end
    endtask

    task automatic checkField(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string name, input bit ev, input int ech,
                               input int ex, input int ey, input bit et);
        checkField({name, ".valid"}, out_valid, ev);
        if (ev) begin
            checkField({name, ".ch"}, out_ch, ech);
            checkField({name, ".x"}, out_x, ex);
            checkField({name, ".y"}, out_y, ey);
            checkField({name, ".transparent"}, out_transparent, et);
        end
    endtask

    task automatic checkModel(input string name);
        checkOutput(name, m_v, m_ch, int'(m_x), int'(m_y), m_t);
    endtask

    task automatic applyStimulus(input logic nf, input logic sr, input logic st,
                                 input logic [0:0] c, input logic [1:0] rw);
        newframe = nf; steprow = sr; step = st; ch = c; ref_wr = rw;
        @(posedge clock);
        model_update();
        #1;
        newframe = 0; steprow = 0; step = 0; ref_wr = '0;
    endtask

    function automatic logic [15:0] rand_param();
        if ($urandom_range(0, 1) == 1) return 16'($urandom);
        return 16'(int'($urandom_range(0, 1023)) - 512);
    endfunction

    function automatic logic [REF_W-1:0] rand_ref();
        if ($urandom_range(0, 3) == 0) return REF_W'($urandom);
        return REF_W'(int'($urandom_range(0, 1400 * 256)) - 200 * 256);
    endfunction

    initial begin
        model_reset();
        #12;
        checkOutput("reset", 1'b0, 0, 0, 0, 1'b0);
        checkField("reset.ch", out_ch, 0);
        checkField("reset.x", out_x, 0);
        checkField("reset.y", out_y, 0);
        checkField("reset.transparent", out_transparent, 0);
        @(negedge clock) reset = 1'b0;
        @(posedge clock) #1;

        // Identity on ch0, then 0.5 scale from refx=10.0 on ch1.
        pa = {16'h0080, 16'h0100}; pb = '0; pc = '0; pd = {16'h0000, 16'h0100};
        refx = {28'h0000A00, 28'h0}; refy = '0; wrap_en = 2'b11; map_size = '0;
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 1, 0, 0, 1, 0, 1, 0, 0};
        tbl[3]  = '{0, 0, 1, 0, 0, 1, 0, 2, 0, 0};
        tbl[4]  = '{0, 0, 1, 0, 0, 1, 0, 3, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
        tbl[8]  = '{0, 0, 1, 1, 0, 1, 1, 10, 0, 0};
        tbl[9]  = '{0, 0, 1, 1, 0, 1, 1, 10, 0, 0};
        tbl[10] = '{0, 0, 1, 1, 0, 1, 1, 11, 0, 0};
        tbl[11] = '{0, 0, 1, 1, 0, 1, 1, 11, 0, 0};
        for (int i = 0; i < 12; i++) begin
            applyStimulus(tbl[i].nf, tbl[i].sr, tbl[i].st, tbl[i].c, tbl[i].rw);
            checkOutput($sformatf("table[%0d]", i), tbl[i].ev, tbl[i].ech,
                        tbl[i].ex, tbl[i].ey, tbl[i].et);
        end

        // Negative start, wrapping then transparent.
        refx = {28'h0, 28'hFFFFE00}; refy = '0; wrap_en = 2'b01;
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0); checkOutput("negwrap0", 1, 0, 126, 0, 0);
        applyStimulus(0, 0, 1, 0, 0); checkOutput("negwrap1", 1, 0, 127, 0, 0);
        applyStimulus(0, 0, 1, 0, 0); checkOutput("negwrap2", 1, 0, 0, 0, 0);
        wrap_en = 2'b00;
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0); checkOutput("negtrans0", 1, 0, 126, 0, 1);
        applyStimulus(0, 0, 1, 0, 0); checkOutput("negtrans1", 1, 0, 127, 0, 1);
        applyStimulus(0, 0, 1, 0, 0); checkOutput("negtrans2", 1, 0, 0, 0, 0);

        // Upper map edge and map size selection.
        refx = {28'h0, 28'h0007F00};
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0); checkOutput("edge127", 1, 0, 127, 0, 0);
        applyStimulus(0, 0, 1, 0, 0); checkOutput("edge128", 1, 0, 0, 0, 1);
        refx = {28'h0, 28'h000C800}; map_size = 4'b0001;
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0); checkOutput("map256", 1, 0, 200, 0, 0);
        map_size = 4'b0000;
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0); checkOutput("map128", 1, 0, 72, 0, 1);

        // Mid-row reference write is deferred to the next row.
        refx = '0; refy = '0; wrap_en = 2'b11;
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0); checkOutput("midrow0", 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0); checkOutput("midrow1", 1, 0, 1, 0, 0);
        refy = {28'h0, 28'h0003200};
        applyStimulus(0, 0, 1, 0, 2'b01); checkOutput("midrow2", 1, 0, 2, 0, 0);
        applyStimulus(0, 0, 1, 0, 0); checkOutput("midrow3", 1, 0, 3, 0, 0);
        applyStimulus(0, 1, 0, 0, 0); checkOutput("midrow.sr", 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0); checkOutput("midrow.reload", 1, 0, 0, 50, 0);

        // Priority and channel isolation.
        refx = {28'h0000700, 28'h0000500}; refy = {28'h0000800, 28'h0000600};
        applyStimulus(1, 1, 1, 0, 2'b11); checkOutput("prio.nf", 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0); checkOutput("inter0", 1, 0, 5, 6, 0);
        applyStimulus(0, 0, 1, 1, 0); checkOutput("inter1", 1, 1, 7, 8, 0);
        applyStimulus(0, 0, 1, 0, 0); checkOutput("inter2", 1, 0, 6, 6, 0);
        applyStimulus(0, 0, 1, 1, 0); checkOutput("inter3", 1, 1, 7, 8, 0);
        applyStimulus(0, 0, 1, 0, 0); checkOutput("inter4", 1, 0, 7, 6, 0);
        applyStimulus(0, 0, 1, 1, 0); checkOutput("inter5", 1, 1, 8, 8, 0);
        applyStimulus(0, 1, 1, 0, 0); checkOutput("prio.sr", 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0); checkOutput("prio.row0", 1, 0, 5, 7, 0);
        applyStimulus(0, 0, 1, 1, 0); checkOutput("prio.row1", 1, 1, 7, 8, 0);

        // Asynchronous reset between edges.
        applyStimulus(0, 0, 1, 0, 0); checkOutput("prereset", 1, 0, 6, 7, 0);
        #2 reset = 1'b1;
        #1;
        checkField("areset.valid", out_valid, 0);
        checkField("areset.x", out_x, 0);
        checkField("areset.y", out_y, 0);
        model_reset();
        @(negedge clock) reset = 1'b0;
        @(posedge clock) #1;
        applyStimulus(0, 0, 0, 0, 0); checkOutput("postreset.idle", 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0); checkOutput("postreset.nf", 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0); checkOutput("postreset.step", 1, 1, 7, 8, 0);

        // Random traffic against the model.
        applyStimulus(1, 0, 0, 0, 0);
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                pa = {rand_param(), rand_param()}; pb = {rand_param(), rand_param()};
                pc = {rand_param(), rand_param()}; pd = {rand_param(), rand_param()};
                wrap_en = 2'($urandom); map_size = 4'($urandom);
            end
            if ($urandom_range(0, 7) == 0) begin
                refx = {rand_ref(), rand_ref()}; refy = {rand_ref(), rand_ref()};
            end
            applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0,
                          $urandom_range(0, 3) != 0, 1'($urandom),
                          {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0});
            checkModel($sformatf("rand[%0d]", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
